// File: rtl/insmem_arbiter.sv
// insmem_arbiter: shares the single-port instruction BRAM between the fetch
// stage and a debug read port. Fetch has fixed priority, and a starvation
// counter forces a debug grant after STARVE_LIMIT denied cycles. Each read
// is tagged with its owner so the response returns to the port that issued it.
module insmem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  dbg_ready,
    output logic                  dbg_valid,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DBG   = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [3:0]            starve_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] fetch_hold;
    logic [DATA_WIDTH-1:0] dbg_hold;
    logic                  dbg_wins;
    logic                  fetch_grant;
    logic                  dbg_grant;

    // Grant decision: fetch priority unless debug has been starved to the limit
    always_comb begin
        dbg_wins    = dbg_req && (!fetch_req || (starve_cnt == LIMIT));
        dbg_grant   = rst_n && dbg_wins;
        fetch_grant = rst_n && fetch_req && !dbg_wins;
        fetch_ready = fetch_grant;
        dbg_ready   = dbg_grant;
        if (fetch_grant) begin
            mem_addr = fetch_addr;
        end else if (dbg_grant) begin
            mem_addr = dbg_addr;
        end else begin
            mem_addr = addr_q;
        end
        if (fetch_grant) begin
            state_nxt = FETCH;
        end else if (dbg_grant) begin
            state_nxt = DBG;
        end else begin
            state_nxt = IDLE;
        end
    end

    // Owner tag, starvation counter and last-granted address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= mem_addr;
            if (dbg_req && !dbg_grant) begin
                starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // The BRAM word arrives in the cycle after accept, so the response cycle
    // forwards mem_rdata directly and the hold register keeps it afterwards.
    // Valids are masked by rst_n so a read accepted just before reset never pulses.
    always_comb begin
        fetch_valid = rst_n && (state == FETCH);
        dbg_valid   = rst_n && (state == DBG);
        fetch_data  = fetch_valid ? mem_rdata : fetch_hold;
        dbg_data    = dbg_valid   ? mem_rdata : dbg_hold;
    end

    // Capture each port's response word so it holds until that port's next read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_hold <= '0;
            dbg_hold   <= '0;
        end else begin
            if (fetch_valid) begin
                fetch_hold <= mem_rdata;
            end
            if (dbg_valid) begin
                dbg_hold <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_insmem_arbiter.sv
// Scoreboard bench for insmem_arbiter: directed request vectors push the
// expected response word and cycle; a monitor pops on every *_valid pulse.
module tb_insmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, dbg_req;
    logic [31:0] fetch_addr, dbg_addr;
    logic        fetch_ready, fetch_valid, dbg_ready, dbg_valid;
    logic [31:0] fetch_data, dbg_data, mem_addr, mem_rdata;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        fq[$];
    exp_t        dq[$];
    logic [31:0] mem [16];
    int unsigned cyc = 0;
    int          nvec = 0;
    int          nmis = 0;

    insmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ready(dbg_ready),
        .dbg_valid(dbg_valid), .dbg_data(dbg_data),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one-cycle registered read, word indexed
    always @(posedge clk) mem_rdata <= mem[mem_addr[5:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One cycle of stimulus plus expected readies and mem_addr
    task automatic step(input logic rst, input logic fr, input logic [31:0] fa,
                        input logic dr, input logic [31:0] da,
                        input logic efr, input logic edr, input logic [31:0] ema);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; fetch_req = fr; fetch_addr = fa; dbg_req = dr; dbg_addr = da;
        if (!rst) begin
            fq.delete();
            dq.delete();
        end
        @(negedge clk);
        #1;
        check("fetch_ready", {31'd0, fetch_ready}, {31'd0, efr});
        check("dbg_ready", {31'd0, dbg_ready}, {31'd0, edr});
        check("mem_addr", mem_addr, ema);
        if (efr) begin
            e.data = mem[fa[5:2]]; e.cyc = cyc + 1; fq.push_back(e);
        end
        if (edr) begin
            e.data = mem[da[5:2]]; e.cyc = cyc + 1; dq.push_back(e);
        end
    endtask

    // Monitor: pop and compare on every response pulse
    always @(negedge clk) begin
        exp_t e;
        if (fetch_valid && dbg_valid) check("both_valid", 32'd1, 32'd0);
        if (fetch_valid) begin
            if (fq.size() == 0) begin
                check("fetch_unexpected", 32'd1, 32'd0);
            end else begin
                e = fq.pop_front();
                check("fetch_data", fetch_data, e.data);
                check("fetch_cycle", cyc, e.cyc);
            end
        end
        if (dbg_valid) begin
            if (dq.size() == 0) begin
                check("dbg_unexpected", 32'd1, 32'd0);
            end else begin
                e = dq.pop_front();
                check("dbg_data", dbg_data, e.data);
                check("dbg_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        mem[0] = 32'h00000013; mem[1] = 32'h00100093;
        mem[2] = 32'h00200113; mem[3] = 32'h00300193;
        for (int i = 4; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst_n = 1'b0; fetch_req = 1'b0; dbg_req = 1'b0;
        fetch_addr = '0; dbg_addr = '0;

        // Reset held with both requests high
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h4, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        check("rst_fetch_data", fetch_data, 32'h0);
        check("rst_dbg_data", dbg_data, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Fetch stream
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'(4 * i), 1'b0, 32'h0, 1'b1, 1'b0, 32'(4 * i));
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hC);
        check("fetch_data_hold", fetch_data, 32'h00300193);

        // Starvation: debug forced in the 5th cycle, fetch regranted next
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h20 + 32'(4 * i), 1'b1, 32'h10, 1'b1, 1'b0, 32'h20 + 32'(4 * i));
        step(1'b1, 1'b1, 32'h30, 1'b1, 32'h10, 1'b0, 1'b1, 32'h10);
        step(1'b1, 1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 1'b0, 32'h30);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h30);

        // Interleave debug and fetch on alternate cycles
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 32'h14, 1'b0, 1'b1, 32'h14);
            step(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8);
        check("dbg_data_hold", dbg_data, mem[5]);

        // Reset mid-read: accepted fetch must not pulse
        step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("post_rst_fetch_data", fetch_data, 32'h0);
        check("post_rst_dbg_data", dbg_data, 32'h0);
        step(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8);

        check("fetch_outstanding", 32'(fq.size()), 32'd0);
        check("dbg_outstanding", 32'(dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
